// File: rtl/rf_spill_fill_ctrl_pkg.sv
// rf_parameters: shared sizes, FSM state type and stack address helper for rf_spill_fill_ctrl.
package rf_parameters;
  localparam int NBITS = 64;
  localparam int N = 3;
  localparam int DEPTH_WIN = 8;
  localparam int WPW = 2 * N;
  localparam int RAM_DEPTH = DEPTH_WIN * WPW;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(DEPTH_WIN + 1);
  localparam int WCW = $clog2(WPW);
  typedef enum logic [1:0] {SF_IDLE, SF_SPILL, SF_FILL} sf_state_t;
  function automatic logic [AW-1:0] sf_addr(input logic [CW-1:0] win, input logic [WCW-1:0] wc);
    return AW'(int'(win) * WPW + int'(wc));
  endfunction
endpackage

// File: rtl/rf_spill_fill_ctrl_stack_mem.sv
// rf_stack_mem: single-port synchronous window-stack RAM, 1-cycle read latency, no reset.
module rf_stack_mem #(
  parameter int DW = 64,
  parameter int AW = 6,
  parameter int DEPTH = 48
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/rf_spill_fill_ctrl.sv
// rf_spill_fill_ctrl: LIFO spill/fill backing store for the windowed RF.
// Optional stored even parity per word when RF_SPILL_PARITY_EN is defined.
module rf_spill_fill_ctrl
  import rf_parameters::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             spill,
  input  logic             fill,
  input  logic [NBITS-1:0] mem_bus,
  output logic [NBITS-1:0] mem_busRead,
  output logic             fill_valid,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             unf,
  output logic             proto_err,
  output logic             parity_err,
  output logic [CW-1:0]    win_cnt
);
`ifdef RF_SPILL_PARITY_EN
  localparam int DW = NBITS + 1;
`else
  localparam int DW = NBITS;
`endif
  sf_state_t state_q, state_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic done_q, done_d, fv_q, fv_d;
  logic ovf_q, ovf_d, unf_q, unf_d, proto_q, proto_d, par_q, par_d;
  logic spill_ok, fill_ok, last, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  rf_stack_mem #(.DW(DW), .AW(AW), .DEPTH(RAM_DEPTH)) u_mem (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SF_IDLE;
      wc_q <= '0;
      win_cnt_q <= '0;
      done_q <= 1'b0;
      fv_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      proto_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q <= wc_d;
      win_cnt_q <= win_cnt_d;
      done_q <= done_d;
      fv_q <= fv_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      proto_q <= proto_d;
      par_q <= par_d;
    end
  end
  always_comb begin
    state_d = spill_ok ? SF_SPILL : fill_ok ? SF_FILL : (state_q != SF_IDLE && last) ? SF_IDLE : state_q;
  end
  // The last fill word is still on rdata the cycle after FILL ends, so busy covers fv_q too.
  always_comb begin
    busy = state_q != SF_IDLE || fv_q;
    spill_ok = !busy && spill && win_cnt_q != CW'(DEPTH_WIN);
    fill_ok = !busy && fill && !spill && win_cnt_q != '0;
    last = wc_q == WCW'(WPW - 1);
    wc_d = spill_ok ? WCW'(1) : (state_q != SF_IDLE && !last) ? wc_q + 1'b1 : '0;
    win_cnt_d = (state_q == SF_SPILL && last) ? win_cnt_q + 1'b1 :
                (state_q == SF_FILL && last) ? win_cnt_q - 1'b1 : win_cnt_q;
    done_d = state_q != SF_IDLE && last;
    fv_d = state_q == SF_FILL;
    ovf_d = ovf_q | (!busy && spill && win_cnt_q == CW'(DEPTH_WIN));
    unf_d = unf_q | (!busy && fill && !spill && win_cnt_q == '0);
    proto_d = proto_q | (busy && (spill || fill)) | (spill && fill);
    we = spill_ok || state_q == SF_SPILL;
    addr = sf_addr(state_q == SF_FILL ? win_cnt_q - 1'b1 : win_cnt_q, wc_q);
`ifdef RF_SPILL_PARITY_EN
    wdata = {^mem_bus, mem_bus};
    par_d = par_q | (fv_q && ((^rdata[NBITS-1:0]) != rdata[NBITS]));
`else
    wdata = mem_bus;
    par_d = 1'b0;
`endif
  end
  always_comb begin
    mem_busRead = fv_q ? rdata[NBITS-1:0] : '0;
    fill_valid = fv_q;
    done = done_q;
    ovf = ovf_q;
    unf = unf_q;
    proto_err = proto_q;
    parity_err = par_q;
    win_cnt = win_cnt_q;
  end
endmodule

// File: tb/tb_rf_spill_fill_ctrl.sv
// tb_rf_spill_fill_ctrl: table-driven plus random checks against a queue-of-windows LIFO model.
// Define RF_SPILL_PARITY_EN to exercise the stored-parity path.
module tb_rf_spill_fill_ctrl;
  typedef logic [63:0] win_t [6];
  typedef struct {
    int op;
    logic [7:0] seed;
    int exp_cnt;
    bit exp_ovf;
    bit exp_unf;
    bit exp_proto;
  } vec_t;
  logic clk = 0, rst = 1, spill = 0, fill = 0;
  logic [63:0] mem_bus = '0, mem_busRead;
  logic fill_valid, busy, done, ovf, unf, proto_err, parity_err;
  logic [3:0] win_cnt;
  int checks = 0, errors = 0;
  win_t stk[$];
  vec_t tbl[$];
  rf_spill_fill_ctrl dut (
    .clk(clk), .rst(rst), .spill(spill), .fill(fill), .mem_bus(mem_bus),
    .mem_busRead(mem_busRead), .fill_valid(fill_valid), .busy(busy), .done(done),
    .ovf(ovf), .unf(unf), .proto_err(proto_err), .parity_err(parity_err), .win_cnt(win_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic win_t mk(input logic [7:0] s);
    win_t w;
    for (int k = 0; k < 6; k++) w[k] = 64'(s) + 64'(k + 1);
    return w;
  endfunction
  function automatic win_t mkr();
    win_t w;
    for (int k = 0; k < 6; k++) w[k] = {$urandom, $urandom};
    return w;
  endfunction
  task automatic spill_op(input win_t w, input bit with_fill);
    bit acc = stk.size() < 8;
    @(negedge clk);
    spill = 1; fill = with_fill; mem_bus = w[0];
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      spill = 0; fill = 0; mem_bus = w[k];
      chk("spill_busy", busy, acc);
      chk("spill_early_done", done, 0);
    end
    @(negedge clk);
    mem_bus = '0;
    chk("spill_done", done, acc);
    if (acc) stk.push_back(w);
    chk("spill_win_cnt", win_cnt, stk.size());
  endtask
  task automatic fill_op(input bit inj);
    bit acc = stk.size() > 0;
    win_t e;
    if (acc) e = stk[stk.size() - 1];
    @(negedge clk);
    fill = 1;
    chk("fill_valid_t0", fill_valid, 0);
    @(negedge clk);
    fill = 0;
    chk("fill_valid_t1", fill_valid, 0);
    chk("fill_busy_t1", busy, acc);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      spill = inj && acc && k == 1;
      mem_bus = spill ? 64'hDEAD_BEEF_0BAD_F00D : '0;
      chk("fill_valid", fill_valid, acc);
      chk("fill_data", mem_busRead, acc ? e[k] : 64'h0);
      chk("fill_done", done, acc && k == 5);
      if (acc && k == 5) chk("fill_win_cnt_at_done", win_cnt, stk.size() - 1);
    end
    @(negedge clk);
    spill = 0; mem_bus = '0;
    chk("fill_valid_after", fill_valid, 0);
    chk("fill_busy_after", busy, 0);
    chk("fill_read_zero", mem_busRead, 0);
    if (acc) void'(stk.pop_back());
    chk("fill_win_cnt", win_cnt, stk.size());
  endtask
  task automatic run_op(input int op, input win_t w);
    if (op == 0) spill_op(w, 0);
    else if (op == 1) fill_op(0);
    else if (op == 2) spill_op(w, 1);
    else fill_op(1);
  endtask
  initial begin
    tbl.push_back(vec_t'{0, 8'h10, 1, 0, 0, 0});
    tbl.push_back(vec_t'{1, 8'h00, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 8'hA0, 1, 0, 0, 0});
    tbl.push_back(vec_t'{0, 8'hB0, 2, 0, 0, 0});
    tbl.push_back(vec_t'{0, 8'hC0, 3, 0, 0, 0});
    tbl.push_back(vec_t'{1, 8'h00, 2, 0, 0, 0});
    tbl.push_back(vec_t'{1, 8'h00, 1, 0, 0, 0});
    tbl.push_back(vec_t'{1, 8'h00, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 8'h00, 0, 0, 1, 0});
    tbl.push_back(vec_t'{2, 8'h20, 1, 0, 1, 1});
    tbl.push_back(vec_t'{0, 8'h30, 2, 0, 1, 1});
    tbl.push_back(vec_t'{3, 8'h00, 1, 0, 1, 1});
    tbl.push_back(vec_t'{1, 8'h00, 0, 0, 1, 1});
    for (int i = 0; i < 8; i++) tbl.push_back(vec_t'{0, 8'(8'h40 + 8 * i), i + 1, 0, 1, 1});
    tbl.push_back(vec_t'{0, 8'hF0, 8, 1, 1, 1});
    tbl.push_back(vec_t'{1, 8'h00, 7, 1, 1, 1});
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_read", mem_busRead, 0);
    chk("rst_win_cnt", win_cnt, 0);
    chk("rst_flags", {ovf, unf, proto_err, parity_err}, 0);
    rst = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, mk(tbl[i].seed));
      chk("tbl_win_cnt", win_cnt, tbl[i].exp_cnt);
      chk("tbl_ovf", ovf, tbl[i].exp_ovf);
      chk("tbl_unf", unf, tbl[i].exp_unf);
      chk("tbl_proto", proto_err, tbl[i].exp_proto);
    end
    spill_op(mk(8'h90), 0);
`ifdef RF_SPILL_PARITY_EN
    begin
      int a = (stk.size() - 1) * 6 + 2;
      win_t t = stk.pop_back();
      dut.u_mem.mem[a][5] = ~dut.u_mem.mem[a][5];
      t[2][5] = ~t[2][5];
      stk.push_back(t);
    end
    fill_op(0);
    chk("parity_err_set", parity_err, 1);
`else
    fill_op(0);
    chk("parity_err_off", parity_err, 0);
`endif
    for (int i = 0; i < 150; i++) run_op($urandom_range(0, 1), mkr());
    chk("rand_win_cnt", win_cnt, stk.size());
    if (stk.size() == 8) fill_op(0);
    @(negedge clk);
    spill = 1; mem_bus = 64'h1234;
    @(negedge clk);
    spill = 0;
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_win_cnt", win_cnt, 0);
    chk("arst_fill_valid", fill_valid, 0);
    chk("arst_flags", {ovf, unf, proto_err, parity_err}, 0);
    @(negedge clk);
    rst = 0;
    stk.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    spill_op(mk(8'h70), 0);
    fill_op(0);
    chk("post_rst_flags", {ovf, unf, proto_err, parity_err}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
